stacker_game_core: RTL

- Parametrised next-generation stacker game engine for the game/arcade subsystem.
- A moving block bounces across the active row of a ROWS x COLS table.
- The drop button locks the block onto the row below. Only overlapping cells survive.
- Play speeds up per row. Ends on a miss (lose) or on filling the top row (win), then reports a result word to the score/user logic.

---
 rtl/stacker_pkg.sv | 52 +++++
 rtl/stacker_tick_gen.sv | 25 ++
 rtl/stacker_game_core.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/stacker_pkg.sv
// Shared types and constants for the stacker game engine.
// Provides state/direction enums, play-state code, game_data layout and step-period helper.
package stacker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    EOG  = 2'd2
  } state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [1:0] GS_PLAY = 2'b01;

  localparam int unsigned GD_WIN_BIT   = 0;
  localparam int unsigned GD_PAUSE_BIT = 1;
  localparam int unsigned GD_ROWS_LSB  = 8;
  localparam int unsigned GD_USER_LSB  = 16;

  // max(tick_div - rows*speedup, min_div), saturating instead of wrapping; never zero.
  function automatic logic [31:0] step_period(input logic [31:0] tick_div,
                                              input logic [31:0] speedup,
                                              input logic [31:0] min_div,
                                              input logic [7:0]  rows);
    logic [39:0] cut;
    logic [31:0] p;
    cut = 40'(rows) * 40'(speedup);
    if (cut >= 40'(tick_div)) begin
      p = min_div;
    end else begin
      p = tick_div - cut[31:0];
      if (p < min_div) p = min_div;
    end
    if (p == '0) p = 32'd1;
    return p;
  endfunction

  function automatic logic [31:0] pack_data(input logic [15:0] user,
                                            input logic [7:0]  rows,
                                            input logic        win);
    logic [31:0] d;
    d = '0;
    d[GD_USER_LSB +: 16] = user;
    d[GD_ROWS_LSB +: 8]  = rows;
    d[GD_WIN_BIT]        = win;
    return d;
  endfunction

endpackage

// File: rtl/stacker_tick_gen.sv
// Loadable down-counter producing a one-cycle tick every `period` enabled cycles.
module stacker_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] period,
  input  logic        clear,
  input  logic        enable,
  output logic        tick
);

  logic [31:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= period - 32'd1;
    end else if (enable) begin
      count <= (count == '0) ? period - 32'd1 : count - 32'd1;
    end
  end

  assign tick = enable && (count == '0);

endmodule

// File: rtl/stacker_game_core.sv
// Stacker game engine: bouncing block, drop-to-lock with overlap trimming, per-row speedup.
// Optional pause button support is enabled with `define STACKER_PAUSE_EN.
module stacker_game_core
  import stacker_pkg::*;
#(
  parameter int unsigned COLS       = 8,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned INIT_WIDTH = 3,
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned SPEEDUP    = 2000000,
  parameter int unsigned MIN_DIV    = 2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           buttons,
  input  logic [15:0]          userid,
  input  logic [1:0]           gamestate,
  output logic                 game_eog,
  output logic [ROWS*COLS-1:0] game_table,
  output logic [COLS-1:0]      game_display,
  output logic [31:0]          game_data
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam logic [COLS-1:0] INIT_PATTERN = COLS'((64'd1 << INIT_WIDTH) - 64'd1);

  state_t          state;
  dir_t            dir;
  dir_t            stepped_dir;
  logic [RW-1:0]   row;
  logic [7:0]      rows_done;
  logic [7:0]      period_rows;
  logic [COLS-1:0] pattern;
  logic [COLS-1:0] rows_q [ROWS];
  logic [COLS-1:0] below;
  logic [COLS-1:0] overlap;
  logic [COLS-1:0] stepped;
  logic [15:0]     user_q;
  logic [31:0]     data_q;
  logic [31:0]     period;
  logic [1:0]      buttons_q;
  logic            play;
  logic            drop_edge;
  logic            lock;
  logic            paused;
  logic            tick;
  logic            unused_bits;

  assign unused_bits = ^{buttons[2], buttons_q[1]};

  always_comb begin
    play        = (gamestate == GS_PLAY);
    drop_edge   = buttons[0] & ~buttons_q[0];
    lock        = (state == MOVE) && play && drop_edge && !paused;
    below       = (row == '0) ? pattern : rows_q[row - 1'b1];
    overlap     = pattern & below;
    stepped     = pattern;
    stepped_dir = dir;
    // A full-width block has nowhere to go, so it stays put instead of bouncing out.
    if (!(pattern[COLS-1] && pattern[0])) begin
      if (dir == DIR_LEFT) begin
        if (pattern[COLS-1]) begin
          stepped     = pattern >> 1;
          stepped_dir = DIR_RIGHT;
        end else begin
          stepped = pattern << 1;
        end
      end else begin
        if (pattern[0]) begin
          stepped     = pattern << 1;
          stepped_dir = DIR_LEFT;
        end else begin
          stepped = pattern >> 1;
        end
      end
    end
    // The counter reloads on the lock edge, so it must see the period of the row being entered.
    period_rows = (state != MOVE) ? '0 : rows_done + {7'b0, lock};
    period      = step_period(TICK_DIV, SPEEDUP, MIN_DIV, period_rows);
  end

  stacker_tick_gen u_tick (
    .clk    (clk),
    .rst    (rst),
    .period (period),
    .clear  ((state != MOVE) || lock),
    .enable ((state == MOVE) && !paused),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      dir          <= DIR_LEFT;
      row          <= '0;
      rows_done    <= '0;
      pattern      <= '0;
      user_q       <= '0;
      data_q       <= '0;
      game_eog     <= 1'b0;
      game_display <= '0;
      buttons_q    <= '0;
      for (int unsigned r = 0; r < ROWS; r++) rows_q[r] <= '0;
    end else begin
      buttons_q <= buttons[1:0];
      unique case (state)
        IDLE: begin
          if (play) begin
            state <= MOVE;
            for (int unsigned r = 0; r < ROWS; r++) rows_q[r] <= '0;
            rows_q[0]    <= INIT_PATTERN;
            row          <= '0;
            rows_done    <= '0;
            user_q       <= userid;
            pattern      <= INIT_PATTERN;
            dir          <= DIR_LEFT;
            game_display <= INIT_PATTERN;
          end
        end
        MOVE: begin
          if (!play) begin
            state <= IDLE;
          end else if (lock) begin
            rows_q[row] <= overlap;
            if (overlap == '0) begin
              state    <= EOG;
              game_eog <= 1'b1;
              data_q   <= pack_data(user_q, rows_done, 1'b0);
            end else if (row == RW'(ROWS - 1)) begin
              rows_done <= 8'(ROWS);
              state     <= EOG;
              game_eog  <= 1'b1;
              data_q    <= pack_data(user_q, 8'(ROWS), 1'b1);
            end else begin
              rows_done            <= rows_done + 8'd1;
              row                  <= row + 1'b1;
              rows_q[row + 1'b1]   <= overlap;
              pattern              <= overlap;
              game_display         <= overlap;
            end
          end else if (tick) begin
            pattern      <= stepped;
            dir          <= stepped_dir;
            rows_q[row]  <= stepped;
            game_display <= stepped;
          end
        end
        EOG: begin
          if (!play) begin
            state    <= IDLE;
            game_eog <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_table
    assign game_table[r*COLS +: COLS] = rows_q[r];
  end

`ifdef STACKER_PAUSE_EN
  logic pause_edge;
  assign pause_edge = buttons[1] & ~buttons_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paused <= 1'b0;
    end else if ((state != IDLE) && !play) begin
      paused <= 1'b0;
    end else if ((state == MOVE) && pause_edge) begin
      paused <= ~paused;
    end
  end

  always_comb begin
    game_data               = data_q;
    game_data[GD_PAUSE_BIT] = paused;
  end
`else
  assign paused    = 1'b0;
  assign game_data = data_q;
`endif

endmodule
